cpu4bit_ctrl_fsm: RTL and testbench
===================================

CPU4BIT_CTRL_FSM -- requirements
Module: cpu4bit_ctrl_fsm

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clock and reset.
REQ-002 The ports SHALL be, one per line, name, direction, width, meaning:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- run  in  1  level enable; leave IDLE / continue fetching
- instr  in  8  instruction word; opcode=instr[7:4], Ry=instr[3:2], Rz=instr[1:0]
- zero  in  1  ALU zero flag, valid in EXEC
- memReady  in  1  data-memory done (used only with CTRL_MEM_WAIT_EN)
- irWrite, pcWrite, pcSrc  out  1 each  latch IR; update PC; 0=PC+1, 1=branch target
- Reg2Loc  out  1  register-address mux select, 0=Ry, 1=Rz
- RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc  out  1 each  datapath controls
- ALUOp  out  2  00 add, 01 sub, 10 and, 11 or
- halted, illegal  out  1 each  in HALT; one-cycle pulse on undefined opcode
- state  out  3  current state encoding
- instrCount  out  8  count of decoded instructions

Function
REQ-003 States and encodings SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; 7 is unreachable and SHALL recover to IDLE on the next cycle.
REQ-004 IDLE SHALL go to FETCH when run=1 and otherwise stay in IDLE.
REQ-005 FETCH SHALL assert irWrite=1 and pcWrite=1 (pcSrc=0) for exactly one cycle, then go to DECODE.
REQ-006 DECODE SHALL latch the opcode internally, increment instrCount by 1 (wrapping 255->0), and go to EXEC.
REQ-007 DECODE and EXEC SHALL drive Reg2Loc=1 for ST (6) and CBZ (7), and Reg2Loc=0 for all other opcodes.
REQ-008 Opcodes 1-4 (ADD, SUB, AND, OR) SHALL drive ALUOp 00/01/10/11 in EXEC, then go EXEC->WB, with WB asserting RegWrite=1 and MemtoReg=0.
REQ-009 LD (5) SHALL drive ALUSrc=1 and ALUOp=00 in EXEC, go EXEC->MEM with MemRead=1, then MEM->WB with RegWrite=1 and MemtoReg=1.
REQ-010 ST (6) SHALL drive ALUSrc=1 in EXEC, go EXEC->MEM with MemWrite=1, then MEM->FETCH (or to IDLE per REQ-014).
REQ-011 CBZ (7) SHALL drive ALUOp=01 in EXEC and assert pcWrite=1, pcSrc=1 only when zero=1 in that cycle; B (8) SHALL assert pcWrite=1, pcSrc=1 unconditionally; both then leave EXEC.
REQ-012 NOP (0) SHALL leave EXEC with no controls asserted.
REQ-013 Opcodes 9-E SHALL behave as NOP and pulse illegal=1 in EXEC; opcode F SHALL go EXEC->HALT, hold halted=1, and stay in HALT until reset, ignoring run.
REQ-014 On leaving WB, MEM (ST case) or EXEC (branch/NOP case), the FSM SHALL go to FETCH if run=1 and to IDLE if run=0; a run drop mid-instruction SHALL always let that instruction complete.
REQ-015 Latency from FETCH entry SHALL be: ALU 4 cycles, LD 5, ST 4, B/CBZ/NOP 3.
REQ-016 All controls SHALL be 0 outside the states named above; every output except pcWrite SHALL depend only on state and the latched opcode.

Reset
REQ-017 While reset=1 at a rising edge, the next state SHALL be IDLE, instrCount SHALL be 0, the latched opcode SHALL be 0, and all outputs SHALL be 0; reset SHALL override every state, including HALT and mid-MEM.

Configuration
REQ-018 With CTRL_MEM_WAIT_EN defined, MEM SHALL hold its controls and stay in MEM until memReady=1; reset SHALL still abort it.
REQ-019 Without CTRL_MEM_WAIT_EN, MEM SHALL last exactly one cycle and memReady SHALL be ignored.

Verification
REQ-020 Reset, then run=1 with instr=8'h1_6 (ADD): states 1,2,3,5 occur; RegWrite=1 only in WB; Reg2Loc=0; instrCount=1.
REQ-021 instr=8'h6_9 (ST): Reg2Loc=1 in DECODE and EXEC, MemWrite=1 in MEM for one cycle, return to FETCH after 4 cycles.
REQ-022 CBZ with zero=1: pcWrite=1 and pcSrc=1 in EXEC; repeated with zero=0: pcWrite=0 in EXEC.
REQ-023 LD with CTRL_MEM_WAIT_EN and memReady held low for 3 cycles: 4 MEM cycles with MemRead=1, then WB with MemtoReg=1.
REQ-024 256 NOPs: instrCount wraps to 0; then opcode F: halted=1 persists with run toggling; reset -> IDLE, all outputs 0.
REQ-025 reset asserted during MEM, or run dropped during EXEC: reset gives IDLE on the next cycle; a run drop lets the instruction finish and then enters IDLE.

Source files
------------

// File: rtl/cpu4bit_ctrl_fsm.sv
// rtl/cpu4bit_ctrl_fsm.sv - multi-cycle control FSM for a 4-bit CPU datapath
//
// Purpose:
//   Sequences each instruction through FETCH / DECODE / EXEC / MEM / WB and
//   drives the datapath control strobes for every state. Opcodes 9-E are
//   treated as NOPs and flagged as illegal. Opcode F parks the FSM in HALT
//   until reset.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   synchronous active-high reset
//   run          in   level enable; leave IDLE / keep fetching
//   instr[7:0]   in   instruction word, opcode = instr[7:4]
//   zero         in   ALU zero flag, consumed in EXEC (CBZ)
//   memReady     in   data-memory done, only used with CTRL_MEM_WAIT_EN
//   irWrite      out  latch IR (FETCH)
//   pcWrite      out  update PC
//   pcSrc        out  PC source, 0 = PC+1, 1 = branch target
//   Reg2Loc      out  register-address mux, 0 = Ry, 1 = Rz
//   RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc   out  datapath controls
//   ALUOp[1:0]   out  00 add, 01 sub, 10 and, 11 or
//   halted       out  FSM is in HALT
//   illegal      out  one-cycle pulse in EXEC for opcodes 9-E
//   state[2:0]   out  current state encoding
//   instrCount   out  decoded-instruction counter, wraps 255 -> 0
//
// Configuration:
//   CTRL_MEM_WAIT_EN  when defined, MEM holds until memReady = 1; otherwise
//                     MEM lasts exactly one cycle and memReady is ignored.

module cpu4bit_ctrl_fsm (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] instr,
  input  logic       zero,
  input  logic       memReady,
  output logic       irWrite,
  output logic       pcWrite,
  output logic       pcSrc,
  output logic       Reg2Loc,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       ALUSrc,
  output logic [1:0] ALUOp,
  output logic       halted,
  output logic       illegal,
  output logic [2:0] state,
  output logic [7:0] instrCount
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_LD  = 4'h5;
  localparam logic [3:0] OP_ST  = 4'h6;
  localparam logic [3:0] OP_CBZ = 4'h7;
  localparam logic [3:0] OP_B   = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [2:0] cur_state;
  logic [2:0] nxt_state;
  logic [3:0] op_q;
  logic [7:0] count_q;
  logic       done_state;

  // Register fields are decoded by the datapath, not here.
  logic unused_inputs;
`ifdef CTRL_MEM_WAIT_EN
  assign unused_inputs = ^instr[3:0];
`else
  assign unused_inputs = ^{instr[3:0], memReady};
`endif

  assign state      = cur_state;
  assign instrCount = count_q;

  // End-of-instruction destination: keep fetching only while run is high.
  assign done_state = run ? S_FETCH : S_IDLE;

  // State register, opcode shadow and instruction counter.
  // The opcode is captured on the same edge that loads IR, so it is already
  // stable throughout DECODE and EXEC and outputs never look at live instr.
  always_ff @(posedge clock) begin
    if (reset) begin
      cur_state <= S_IDLE;
      op_q      <= 4'h0;
      count_q   <= 8'h00;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == S_FETCH) begin
        op_q <= instr[7:4];
      end
      if (cur_state == S_DECODE) begin
        count_q <= count_q + 8'd1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    nxt_state = S_IDLE;
    case (cur_state)
      S_IDLE:   nxt_state = run ? S_FETCH : S_IDLE;
      S_FETCH:  nxt_state = S_DECODE;
      S_DECODE: nxt_state = S_EXEC;
      S_EXEC: begin
        case (op_q)
          OP_ADD, OP_SUB, OP_AND, OP_OR: nxt_state = S_WB;
          OP_LD, OP_ST:                  nxt_state = S_MEM;
          OP_HLT:                        nxt_state = S_HALT;
          default:                       nxt_state = done_state;
        endcase
      end
      S_MEM: begin
`ifdef CTRL_MEM_WAIT_EN
        if (!memReady) begin
          nxt_state = S_MEM;
        end else
`endif
        if (op_q == OP_LD) begin
          nxt_state = S_WB;
        end else begin
          nxt_state = done_state;
        end
      end
      S_WB:     nxt_state = done_state;
      S_HALT:   nxt_state = S_HALT;
      default:  nxt_state = S_IDLE;
    endcase
  end

  // Output logic. Everything is a function of state and the latched opcode,
  // except pcWrite for CBZ, which also follows the zero flag in EXEC.
  always_comb begin
    irWrite  = 1'b0;
    pcWrite  = 1'b0;
    pcSrc    = 1'b0;
    Reg2Loc  = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    ALUSrc   = 1'b0;
    ALUOp    = 2'b00;
    halted   = 1'b0;
    illegal  = 1'b0;
    case (cur_state)
      S_FETCH: begin
        irWrite = 1'b1;
        pcWrite = 1'b1;
      end
      S_DECODE: begin
        Reg2Loc = (op_q == OP_ST) || (op_q == OP_CBZ);
      end
      S_EXEC: begin
        Reg2Loc = (op_q == OP_ST) || (op_q == OP_CBZ);
        case (op_q)
          OP_ADD: ALUOp = 2'b00;
          OP_SUB: ALUOp = 2'b01;
          OP_AND: ALUOp = 2'b10;
          OP_OR:  ALUOp = 2'b11;
          OP_LD: begin
            ALUSrc = 1'b1;
            ALUOp  = 2'b00;
          end
          OP_ST:  ALUSrc = 1'b1;
          OP_CBZ: begin
            // pcSrc may sit at 1 while pcWrite is low; the PC ignores it.
            ALUOp   = 2'b01;
            pcSrc   = 1'b1;
            pcWrite = zero;
          end
          OP_B: begin
            pcSrc   = 1'b1;
            pcWrite = 1'b1;
          end
          OP_NOP, OP_HLT: begin
          end
          default: illegal = 1'b1;
        endcase
      end
      S_MEM: begin
        MemRead  = (op_q == OP_LD);
        MemWrite = (op_q == OP_ST);
      end
      S_WB: begin
        RegWrite = 1'b1;
        MemtoReg = (op_q == OP_LD);
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_cpu4bit_ctrl_fsm.sv
// tb/tb_cpu4bit_ctrl_fsm.sv - scoreboard bench for cpu4bit_ctrl_fsm

module tb_cpu4bit_ctrl_fsm;

  logic       clock = 1'b0;
  logic       reset;
  logic       run;
  logic [7:0] instr;
  logic       zero;
  logic       memReady;
  logic       irWrite, pcWrite, pcSrc, Reg2Loc, RegWrite, MemRead, MemWrite;
  logic       MemtoReg, ALUSrc, halted, illegal;
  logic [1:0] ALUOp;
  logic [2:0] state;
  logic [7:0] instrCount;

  cpu4bit_ctrl_fsm dut (
    .clock(clock), .reset(reset), .run(run), .instr(instr), .zero(zero),
    .memReady(memReady), .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc),
    .Reg2Loc(Reg2Loc), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
    .halted(halted), .illegal(illegal), .state(state), .instrCount(instrCount)
  );

  always #5 clock = ~clock;

  // Phase numbers are the architectural state encodings.
  localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3;
  localparam int P_MEM = 4, P_WB = 5, P_HALT = 6;

  // Control vector layout:
  // {irWrite,pcWrite,pcSrc,Reg2Loc,RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,ALUOp[1:0],halted,illegal}
  typedef struct {
    logic [2:0]  st;
    logic [12:0] c;
    logic [12:0] dc;
    logic [7:0]  cnt;
    bit          chk;
  } exp_t;

  exp_t       sbq[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] m_cnt;
  bit         nf;

  // Reference rules: what each phase of an instruction asks of the datapath.
  function automatic logic [12:0] exp_ctrl(input int ph, input logic [3:0] op, input logic z);
    logic [12:0] c;
    c = '0;
    case (ph)
      P_FETCH: begin c[12] = 1'b1; c[11] = 1'b1; end
      P_DECODE: c[9] = (op == 4'd6 || op == 4'd7);
      P_EXEC: begin
        c[9] = (op == 4'd6 || op == 4'd7);
        if (op >= 4'd1 && op <= 4'd4) c[3:2] = 2'(op - 4'd1);
        if (op == 4'd7) c[3:2] = 2'b01;
        c[4] = (op == 4'd5 || op == 4'd6);
        if (op == 4'd8) begin c[11] = 1'b1; c[10] = 1'b1; end
        if (op == 4'd7) begin c[11] = z; c[10] = z; end
        c[0] = (op >= 4'd9 && op <= 4'd14);
      end
      P_MEM: begin c[7] = (op == 4'd5); c[6] = (op == 4'd6); end
      P_WB: begin c[8] = 1'b1; c[5] = (op == 4'd5); end
      P_HALT: c[1] = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic push(input int ph, input logic [12:0] c, input logic [12:0] dc, input bit chk);
    exp_t e;
    e.st = 3'(ph); e.c = c; e.dc = dc; e.cnt = m_cnt; e.chk = chk;
    sbq.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic rand_inputs(input int zsel, input int rsel);
    run      = (rsel == 2) ? ($urandom_range(0, 3) != 0) : (rsel != 0);
    zero     = (zsel == 2) ? 1'($urandom) : (zsel != 0);
    memReady = 1'($urandom);
  endtask

  task automatic idle_cycle(input bit r, output bit next_fetch);
    run = r; zero = 1'($urandom); memReady = 1'($urandom); instr = 8'($urandom);
    push(P_IDLE, '0, '0, 1'b1);
    step();
    next_fetch = r;
  endtask

  task automatic reset_cycle();
    reset = 1'b1;
    push(P_IDLE, '0, '0, 1'b0);
    step();
    reset = 1'b0;
    m_cnt = 8'd0;
  endtask

  // Runs one instruction starting in FETCH. zsel/rsel: 0 or 1 forces
  // zero/run, 2 randomizes per cycle. waits = extra MEM cycles (wait build).
  task automatic do_instr(input logic [3:0] op, input int zsel, input int rsel,
                          input int waits, input bit abort_mem, output bit next_fetch);
    int phs[$];
    int nmem;
    logic [12:0] dc;
    phs = '{P_FETCH, P_DECODE, P_EXEC};
    if (op >= 4'd1 && op <= 4'd4) phs.push_back(P_WB);
    if (op == 4'd5) begin phs.push_back(P_MEM); phs.push_back(P_WB); end
    if (op == 4'd6) phs.push_back(P_MEM);
    instr = {op, 4'($urandom)};
    next_fetch = 1'b0;
    foreach (phs[i]) begin
      if (phs[i] == P_MEM) begin
        nmem = 1;
`ifdef CTRL_MEM_WAIT_EN
        nmem = waits + 1;
`endif
        for (int w = 0; w < nmem; w++) begin
          rand_inputs(zsel, rsel);
`ifdef CTRL_MEM_WAIT_EN
          memReady = (w == nmem - 1);
`endif
          if (abort_mem) reset = 1'b1;
          push(P_MEM, exp_ctrl(P_MEM, op, zero), '0, 1'b1);
          step();
          if (abort_mem) begin
            reset = 1'b0;
            m_cnt = 8'd0;
            next_fetch = 1'b0;
            return;
          end
        end
      end else begin
        rand_inputs(zsel, rsel);
        // pcSrc is a don't-care when a CBZ is not taken.
        dc = (phs[i] == P_EXEC && op == 4'd7 && !zero) ? 13'h0400 : 13'h0000;
        push(phs[i], exp_ctrl(phs[i], op, zero), dc, 1'b1);
        step();
        if (phs[i] == P_DECODE) m_cnt = m_cnt + 8'd1;
      end
      next_fetch = run;
    end
    if (op == 4'hF) begin
      for (int k = 0; k < 8; k++) begin
        run = 1'(k & 1); zero = 1'($urandom); memReady = 1'($urandom);
        push(P_HALT, exp_ctrl(P_HALT, op, zero), '0, 1'b1);
        step();
      end
      reset = 1'b1;
      push(P_HALT, exp_ctrl(P_HALT, op, zero), '0, 1'b1);
      step();
      reset = 1'b0;
      m_cnt = 8'd0;
      next_fetch = 1'b0;
    end
  endtask

  // Monitor: every cycle the DUT presents a state; pop and compare.
  always @(negedge clock) begin
    exp_t e;
    logic [12:0] act;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.chk) begin
        vectors++;
        act = {irWrite, pcWrite, pcSrc, Reg2Loc, RegWrite, MemRead, MemWrite,
               MemtoReg, ALUSrc, ALUOp, halted, illegal};
        if (state !== e.st || (((act ^ e.c) & ~e.dc) !== 13'h0) || instrCount !== e.cnt) begin
          miscompares++;
          $display("FAIL cycle@%0t: state=%0d ctrl=%013b cnt=%0d, required state=%0d ctrl=%013b (dc %013b) cnt=%0d",
                   $time, state, act, instrCount, e.st, e.c, e.dc, e.cnt);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; run = 1'b0; instr = 8'h00; zero = 1'b0; memReady = 1'b0;
    m_cnt = 8'd0;
    step();
    push(P_IDLE, '0, '0, 1'b1);
    step();
    reset = 1'b0;
    idle_cycle(1'b0, nf);
    idle_cycle(1'b1, nf);

    do_instr(4'h1, 2, 1, 0, 1'b0, nf);   // ADD
    do_instr(4'h6, 2, 1, 0, 1'b0, nf);   // ST
    do_instr(4'h7, 1, 1, 0, 1'b0, nf);   // CBZ taken
    do_instr(4'h7, 0, 1, 0, 1'b0, nf);   // CBZ not taken
    do_instr(4'h8, 2, 1, 0, 1'b0, nf);   // B
    do_instr(4'h5, 2, 1, 3, 1'b0, nf);   // LD with 3 wait cycles
    do_instr(4'hA, 2, 1, 0, 1'b0, nf);   // illegal
    do_instr(4'h2, 2, 0, 0, 1'b0, nf);   // run low throughout: finish then IDLE
    idle_cycle(1'b1, nf);
    do_instr(4'h5, 2, 1, 2, 1'b1, nf);   // reset during MEM
    idle_cycle(1'b0, nf);
    idle_cycle(1'b1, nf);

    for (int n = 0; n < 300; n++) begin
      if (nf) do_instr(4'($urandom_range(0, 14)), 2, 2, $urandom_range(0, 3), 1'b0, nf);
      else    idle_cycle(1'($urandom), nf);
    end

    reset_cycle();
    idle_cycle(1'b1, nf);
    for (int n = 0; n < 256; n++) do_instr(4'h0, 2, 1, 0, 1'b0, nf);
    do_instr(4'hF, 2, 1, 0, 1'b0, nf);   // halt, run toggling, then reset
    idle_cycle(1'b0, nf);
    idle_cycle(1'b0, nf);

    repeat (2) @(posedge clock);
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, required 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
